// File: rtl/inst_buffer_if.sv
// inst_buffer_if: fetch push bus and decode-side group presentation of the instruction buffer
interface inst_buffer_if;
    logic [1:0]  if_valid;
    logic [31:0] if_pc0;
    logic [31:0] if_pc1;
    logic [31:0] if_inst0;
    logic [31:0] if_inst1;
    logic [6:0]  if_exception0;
    logic [6:0]  if_exception1;
    logic [31:0] if_badv0;
    logic [31:0] if_badv1;
    logic [1:0]  if_priv;
    logic        fifo_allowin;
    logic        id_allowin;
    logic        fifo_readygo;
    logic [1:0]  fifo_id_valid;
    logic [31:0] fifo_id_pc0;
    logic [31:0] fifo_id_pc1;
    logic [31:0] fifo_id_inst0;
    logic [31:0] fifo_id_inst1;
    logic [1:0]  fifo_id_excp_flag;
    logic [6:0]  fifo_id_exception;
    logic [31:0] fifo_id_badv;
    logic [1:0]  fifo_id_priv_flag;

    modport slave (
        input  if_valid, if_pc0, if_pc1, if_inst0, if_inst1, if_exception0, if_exception1,
               if_badv0, if_badv1, if_priv, id_allowin,
        output fifo_allowin, fifo_readygo, fifo_id_valid, fifo_id_pc0, fifo_id_pc1,
               fifo_id_inst0, fifo_id_inst1, fifo_id_excp_flag, fifo_id_exception,
               fifo_id_badv, fifo_id_priv_flag
    );

    modport master (
        output if_valid, if_pc0, if_pc1, if_inst0, if_inst1, if_exception0, if_exception1,
               if_badv0, if_badv1, if_priv, id_allowin,
        input  fifo_allowin, fifo_readygo, fifo_id_valid, fifo_id_pc0, fifo_id_pc1,
               fifo_id_inst0, fifo_id_inst1, fifo_id_excp_flag, fifo_id_exception,
               fifo_id_badv, fifo_id_priv_flag
    );
endinterface

// File: rtl/inst_buffer.sv
// inst_buffer: dual-issue FWFT instruction buffer splitting groups at exception/privileged boundaries
module inst_buffer #(
    parameter int DEPTH = 8
) (
    input logic          aclk,
    input logic          aresetn,
    input logic          flush,
    inst_buffer_if.slave bus
);
    localparam int AW = $clog2(DEPTH);

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
        logic [6:0]  exc;
        logic [31:0] badv;
        logic        priv;
    } entry_t;

    entry_t          mem [DEPTH];
    entry_t          h0, h1, w0, w1;
    logic [AW-1:0]   head, tail, head1, tail1;
    logic [AW:0]     count, push_n, pop_n;
    logic            allowin, push, pop, v0, v1, xf0, xf1;

    // head pair, incoming pair, and handshake bookkeeping
    always_comb begin
        head1   = head + AW'(1);
        tail1   = tail + AW'(bus.if_valid[0]);
        h0      = mem[head];
        h1      = mem[head1];
        w0      = {bus.if_pc0, bus.if_inst0, bus.if_exception0, bus.if_badv0, bus.if_priv[0]};
        w1      = {bus.if_pc1, bus.if_inst1, bus.if_exception1, bus.if_badv1, bus.if_priv[1]};
        allowin = count <= (AW+1)'(DEPTH - 2);
        v0      = count != '0;
        v1      = count >= (AW+1)'(2) && h0.exc == '0 && !h0.priv && !h1.priv;
        xf0     = v0 && h0.exc != '0;
        xf1     = v1 && h1.exc != '0;
        push    = allowin && !flush;
        pop     = v0 && bus.id_allowin && !flush;
        push_n  = push ? (AW+1)'(bus.if_valid[0]) + (AW+1)'(bus.if_valid[1]) : '0;
        pop_n   = pop ? (AW+1)'(v0) + (AW+1)'(v1) : '0;
    end

    // present the group; invalid slots are forced to zero
    always_comb begin
        bus.fifo_allowin      = allowin;
        bus.fifo_readygo      = v0;
        bus.fifo_id_valid     = {v1, v0};
        bus.fifo_id_pc0       = v0 ? h0.pc : '0;
        bus.fifo_id_pc1       = v1 ? h1.pc : '0;
        bus.fifo_id_inst0     = v0 ? h0.inst : '0;
        bus.fifo_id_inst1     = v1 ? h1.inst : '0;
        bus.fifo_id_excp_flag = {xf1, xf0};
        bus.fifo_id_exception = xf0 ? h0.exc : xf1 ? h1.exc : '0;
        bus.fifo_id_badv      = xf0 ? h0.badv : xf1 ? h1.badv : '0;
        bus.fifo_id_priv_flag = {v1 && h1.priv, v0 && h0.priv};
    end

    // write valid slots in order; slot1 alone lands at tail
    always_ff @(posedge aclk) begin
        if (push && bus.if_valid[0]) mem[tail] <= w0;
        if (push && bus.if_valid[1]) mem[tail1] <= w1;
    end

    // pointer and occupancy update; reset and flush clear everything
    always_ff @(posedge aclk) begin
        if (!aresetn || flush) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            head  <= head + pop_n[AW-1:0];
            tail  <= tail + push_n[AW-1:0];
            count <= count + push_n - pop_n;
        end
    end
endmodule

// File: tb/tb_inst_buffer.sv
// tb_inst_buffer: scoreboard bench for inst_buffer
module tb_inst_buffer;
    typedef struct {
        logic [31:0] pc;
        logic [31:0] inst;
        logic [6:0]  exc;
        logic [31:0] badv;
        logic        priv;
    } ent_t;

    logic aclk = 0;
    logic aresetn = 0;
    logic flush = 0;
    int   n_chk = 0;
    int   n_pass = 0;
    logic [31:0] next_pc = 32'h1c000000;
    ent_t sb[$];

    inst_buffer_if bus ();

    inst_buffer #(.DEPTH(8)) dut (
        .aclk   (aclk),
        .aresetn(aresetn),
        .flush  (flush),
        .bus    (bus)
    );

    always #5 aclk = ~aclk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    function automatic ent_t mk(input logic [31:0] pc, input logic [6:0] e, input logic p, input int s);
        ent_t x;
        x.pc   = pc;
        x.inst = ~pc;
        x.exc  = e;
        x.badv = e != 0 ? 32'h00000ff1 + 32'(4 * s) : pc ^ 32'h5a5a0000;
        x.priv = p;
        return x;
    endfunction

    task automatic step(input logic [1:0] v, input logic p0, input logic p1,
                        input logic [6:0] e0, input logic [6:0] e1,
                        input logic alw, input logic fl);
        ent_t a, b, s0, s1;
        logic ev0, ev1, ex0, ex1;
        logic [6:0] eexc;
        logic [31:0] ebadv;
        int n;
        @(negedge aclk);
        a = mk(next_pc, e0, p0, 0);
        b = mk(next_pc + 4, e1, p1, 1);
        next_pc += 8;
        bus.if_valid = v;
        bus.if_pc0 = a.pc;  bus.if_inst0 = a.inst; bus.if_exception0 = a.exc; bus.if_badv0 = a.badv;
        bus.if_pc1 = b.pc;  bus.if_inst1 = b.inst; bus.if_exception1 = b.exc; bus.if_badv1 = b.badv;
        bus.if_priv = {p1, p0};
        bus.id_allowin = alw;
        flush = fl;
        #1;
        n = sb.size();
        s0 = n >= 1 ? sb[0] : mk(0, 0, 0, 0);
        s1 = n >= 2 ? sb[1] : mk(0, 0, 0, 0);
        ev0 = n >= 1;
        ev1 = n >= 2 && s0.exc == 0 && !s0.priv && !s1.priv;
        ex0 = ev0 && s0.exc != 0;
        ex1 = ev1 && s1.exc != 0;
        eexc = ex0 ? s0.exc : ex1 ? s1.exc : 7'd0;
        ebadv = ex0 ? s0.badv : ex1 ? s1.badv : 32'd0;
        check("allowin", 32'(bus.fifo_allowin), 32'(n <= 6));
        check("readygo", 32'(bus.fifo_readygo), 32'(ev0));
        check("valid", 32'(bus.fifo_id_valid), 32'({ev1, ev0}));
        check("pc0", bus.fifo_id_pc0, ev0 ? s0.pc : 32'd0);
        check("pc1", bus.fifo_id_pc1, ev1 ? s1.pc : 32'd0);
        check("inst0", bus.fifo_id_inst0, ev0 ? s0.inst : 32'd0);
        check("inst1", bus.fifo_id_inst1, ev1 ? s1.inst : 32'd0);
        check("excp_flag", 32'(bus.fifo_id_excp_flag), 32'({ex1, ex0}));
        check("exception", 32'(bus.fifo_id_exception), 32'(eexc));
        check("badv", bus.fifo_id_badv, ebadv);
        check("priv_flag", 32'(bus.fifo_id_priv_flag), 32'({ev1 && s1.priv, ev0 && s0.priv}));
        if (fl) sb.delete();
        else begin
            if (alw && ev0) begin
                void'(sb.pop_front());
                if (ev1) void'(sb.pop_front());
            end
            if (n <= 6) begin
                if (v[0]) sb.push_back(a);
                if (v[1]) sb.push_back(b);
            end
        end
    endtask

    task automatic idle(input logic alw, input int k);
        for (int i = 0; i < k; i++) step(2'b00, 0, 0, 0, 0, alw, 0);
    endtask

    task automatic do_reset();
        @(negedge aclk);
        aresetn = 0;
        bus.if_valid = 2'b00;
        @(negedge aclk);
        aresetn = 1;
        sb.delete();
    endtask

    initial begin
        bus.if_valid = 0; bus.if_priv = 0; bus.id_allowin = 0;
        bus.if_pc0 = 0; bus.if_pc1 = 0; bus.if_inst0 = 0; bus.if_inst1 = 0;
        bus.if_exception0 = 0; bus.if_exception1 = 0; bus.if_badv0 = 0; bus.if_badv1 = 0;
        repeat (3) @(negedge aclk);
        aresetn = 1;
        idle(1, 2);
        // pair push then presentation and drain
        step(2'b11, 0, 0, 0, 0, 1, 0);
        idle(1, 2);
        // five singles with decode accepting
        for (int i = 0; i < 5; i++) step(2'b01, 0, 0, 0, 0, 1, 0);
        idle(1, 4);
        // fill with decode stalled; eighth and ninth single ignored
        for (int i = 0; i < 9; i++) step(2'b01, 0, 0, 0, 0, 0, 0);
        idle(0, 2);
        idle(1, 5);
        // slot1-only push
        step(2'b10, 0, 0, 0, 0, 0, 0);
        idle(1, 2);
        // privileged in slot1 splits the group
        step(2'b11, 0, 1, 0, 0, 0, 0);
        idle(0, 1);
        idle(1, 3);
        // privileged in slot0
        step(2'b11, 1, 0, 0, 0, 0, 0);
        idle(1, 3);
        // exception on H0, then on H1 only
        step(2'b11, 0, 0, 7'h03, 0, 0, 0);
        idle(0, 1);
        idle(1, 3);
        step(2'b11, 0, 0, 0, 7'h05, 0, 0);
        idle(0, 1);
        idle(1, 2);
        // flush at count 6 with concurrent push and pop
        for (int i = 0; i < 3; i++) step(2'b11, 0, 0, 0, 0, 0, 0);
        step(2'b11, 0, 0, 0, 0, 1, 1);
        idle(1, 1);
        // walk head to entry 7, then a pair straddling the wrap
        for (int i = 0; i < 7; i++) step(2'b01, 0, 0, 0, 0, 0, 0);
        idle(1, 4);
        step(2'b11, 0, 0, 0, 0, 0, 0);
        idle(0, 1);
        idle(1, 2);
        // random traffic then reset mid-operation
        for (int i = 0; i < 60; i++)
            step(2'($urandom_range(0, 3)), 1'($urandom_range(0, 7) == 0), 1'($urandom_range(0, 7) == 0),
                 $urandom_range(0, 5) == 0 ? 7'h0a : 7'h00, $urandom_range(0, 5) == 0 ? 7'h11 : 7'h00,
                 1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 30) == 0));
        for (int i = 0; i < 3; i++) step(2'b11, 0, 0, 0, 0, 0, 0);
        do_reset();
        idle(1, 2);
        step(2'b11, 0, 0, 0, 0, 1, 0);
        idle(1, 2);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
